// File: rtl/keys_pio_irq.sv
// keys_pio_irq
// Avalon-MM slave for board keys and switches. Each input line is
// synchronised, then debounced. The stable level, the raw synchronised
// level, a per-bit edge capture register and an interrupt mask are
// readable. irq is high whenever a captured edge is also unmasked.
//
// Register map (word offsets):
//   0 DATA         RO    debounced level
//   1 RAW          RO    synchronised level before the debounce filter
//   2 IRQMASK      RW    bits [WIDTH-1:0]
//   3 EDGECAPTURE  R/W1C write 1 to clear; an edge in the same cycle wins
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   in_port     asynchronous key/switch inputs
//   readdata    registered read data (latency 1), zero-extended above WIDTH
//   irq         active-high level interrupt, driven from registers only
module keys_pio_irq #(
    parameter int   WIDTH           = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_TYPE       = 1,
    parameter logic INIT_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE    = {WIDTH{INIT_LEVEL}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edgecapture_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic             unused_wdata;

    // Upper write-data bits have no storage behind them.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= IDLE;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A changed level must be seen on DEBOUNCE_CYCLES consecutive samples;
    // any sample matching the current stable level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= IDLE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= sync[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise     = stable_q & ~prev_q;
    assign fall     = ~stable_q & prev_q;
    assign edge_hit = (EDGE_TYPE == 0) ? rise :
                      (EDGE_TYPE == 1) ? fall : (rise | fall);

    assign wr_en      = chipselect & ~write_n;
    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q        <= IDLE;
            edgecapture_q <= '0;
            irqmask_q     <= '0;
        end else begin
            prev_q <= stable_q;
            // OR-ing the new edge in after the clear keeps a coincident edge.
            edgecapture_q <= (edgecapture_q & ~clear_bits) | edge_hit;
            if (wr_en && address == 2'd2) begin
                irqmask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    // Registered from pre-write state, so a read during a write sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(stable_q);
                2'd1:    readdata <= 32'(sync);
                2'd2:    readdata <= 32'(irqmask_q);
                default: readdata <= 32'(edgecapture_q);
            endcase
        end
    end

    assign irq = |(edgecapture_q & irqmask_q);

endmodule

// File: tb/tb_keys_pio_irq.sv
// Bench for keys_pio_irq with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=1 (falling), INIT_LEVEL=1. Directed scenarios use hand-derived
// constants; the random scenario compares against a reference model in which
// the synchroniser is a delay queue and the debounce is a sliding window of
// recent samples.
module tb_keys_pio_irq;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [3:0]  m_stable, m_prev, m_ec, m_mask;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [3:0]  m_pipe[$];
    logic [3:0]  m_win[$];

    always #5 clk = ~clk;

    keys_pio_irq #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1),
        .INIT_LEVEL(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    task automatic model_reset();
        m_stable = 4'hF;
        m_prev   = 4'hF;
        m_ec     = 4'h0;
        m_mask   = 4'h0;
        m_rd     = 32'h0;
        m_irq    = 1'b0;
        m_pipe.delete();
        for (int s = 0; s < SS; s++) m_pipe.push_back(4'hF);
        m_win.delete();
    endtask

    // One clock edge of the reference model, using the inputs as they were
    // just before the edge.
    task automatic model_step();
        logic [3:0] s;
        logic [3:0] fell;
        logic [3:0] clr;
        logic [3:0] nxt;
        logic       wr;
        logic       flip;
        s = m_pipe[0];
        case (address)
            2'd0:    m_rd = {28'h0, m_stable};
            2'd1:    m_rd = {28'h0, s};
            2'd2:    m_rd = {28'h0, m_mask};
            default: m_rd = {28'h0, m_ec};
        endcase
        wr   = chipselect && !write_n;
        fell = m_prev & ~m_stable;
        clr  = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_ec = (m_ec & ~clr) | fell;
        if (wr && address == 2'd2) m_mask = writedata[3:0];
        m_win.push_back(s);
        if (m_win.size() > DB) void'(m_win.pop_front());
        nxt = m_stable;
        if (m_win.size() == DB) begin
            for (int i = 0; i < W; i++) begin
                flip = 1'b1;
                foreach (m_win[j]) if (m_win[j][i] == m_stable[i]) flip = 1'b0;
                if (flip) nxt[i] = ~m_stable[i];
            end
        end
        m_prev   = m_stable;
        m_stable = nxt;
        void'(m_pipe.pop_front());
        m_pipe.push_back(in_port);
        m_irq = |(m_ec & m_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0000000F, 32'h0000000F, 32'h0, 32'h0};
        reset_n = 1'b0;
        in_port = 4'hF;
        model_reset();
        repeat (3) tick();
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            tick();
            checks++;
            if (readdata !== exp_rd[a]) begin
                failures++;
                $display("FAIL reset_read_addr%0d: got %h expected %h", a, readdata, exp_rd[a]);
            end
            checks++;
            if (irq !== 1'b0) begin
                failures++;
                $display("FAIL reset_read_irq%0d: got %b expected 0", a, irq);
            end
        end
    endtask

    task automatic test_fall_edge();
        address = 2'd1;
        in_port = 4'hE;
        tick();
        tick();
        checks++;
        if (readdata !== 32'hF) begin
            failures++;
            $display("FAIL raw_before: got %h expected %h", readdata, 32'hF);
        end
        tick();
        checks++;
        if (readdata !== 32'hE) begin
            failures++;
            $display("FAIL raw_after: got %h expected %h", readdata, 32'hE);
        end
        address = 2'd0;
        repeat (3) tick();
        checks++;
        if (readdata !== 32'hF) begin
            failures++;
            $display("FAIL data_before_accept: got %h expected %h", readdata, 32'hF);
        end
        tick();
        checks++;
        if (readdata !== 32'hE) begin
            failures++;
            $display("FAIL data_after_accept: got %h expected %h", readdata, 32'hE);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h1) begin
            failures++;
            $display("FAIL edgecapture_set: got %h expected %h", readdata, 32'h1);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_masked: got %b expected 0", irq);
        end
    endtask

    task automatic test_mask();
        bus_write(2'd2, 32'hFFFFFFFF);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_after_mask: got %b expected 1", irq);
        end
        address = 2'd2;
        tick();
        checks++;
        if (readdata !== 32'hF) begin
            failures++;
            $display("FAIL irqmask_readback: got %h expected %h", readdata, 32'hF);
        end
        bus_write(2'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_after_w1c: got %b expected 0", irq);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL edgecapture_cleared: got %h expected %h", readdata, 32'h0);
        end
    endtask

    task automatic test_glitch();
        logic saw;
        in_port = 4'hF;
        repeat (8) tick();
        address = 2'd1;
        saw = 1'b0;
        in_port = 4'hB;
        repeat (3) begin
            tick();
            if (readdata == 32'hB) saw = 1'b1;
        end
        in_port = 4'hF;
        repeat (4) begin
            tick();
            if (readdata == 32'hB) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b1) begin
            failures++;
            $display("FAIL glitch_raw_visible: got %b expected 1", saw);
        end
        address = 2'd0;
        repeat (4) tick();
        checks++;
        if (readdata !== 32'hF) begin
            failures++;
            $display("FAIL glitch_data: got %h expected %h", readdata, 32'hF);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL glitch_edgecapture: got %h expected %h", readdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL glitch_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        in_port = 4'hD;
        repeat (8) tick();
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h2) begin
            failures++;
            $display("FAIL b2b_first_capture: got %h expected %h", readdata, 32'h2);
        end
        in_port = 4'hF;
        repeat (8) tick();
        in_port = 4'hD;
        repeat (6) tick();
        // This write lands on the edge where the new falling edge is captured.
        bus_write(2'd3, 32'h2);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL b2b_irq_kept: got %b expected 1", irq);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h2) begin
            failures++;
            $display("FAIL b2b_set_wins: got %h expected %h", readdata, 32'h2);
        end
        bus_write(2'd3, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL b2b_plain_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_reset_mid_debounce();
        in_port = 4'hF;
        repeat (8) tick();
        bus_write(2'd3, 32'hF);
        address = 2'd2;
        in_port = 4'h7;
        repeat (4) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL midreset_readdata: got %h expected %h", readdata, 32'h0);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL midreset_irqmask: got %h expected %h", readdata, 32'h0);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL midreset_edgecapture: got %h expected %h", readdata, 32'h0);
        end
        address = 2'd0;
        repeat (4) tick();
        checks++;
        if (readdata !== 32'hF) begin
            failures++;
            $display("FAIL midreset_data_early: got %h expected %h", readdata, 32'hF);
        end
        tick();
        checks++;
        if (readdata !== 32'h7) begin
            failures++;
            $display("FAIL midreset_data_accept: got %h expected %h", readdata, 32'h7);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h8) begin
            failures++;
            $display("FAIL midreset_edge_bit3: got %h expected %h", readdata, 32'h8);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL midreset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                in_port = 4'($urandom);
                hold    = int'($urandom_range(1, 9));
            end
            hold--;
            address = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'b1;
            end
            writedata = $urandom;
            tick();
            checks++;
            if (readdata !== m_rd) begin
                failures++;
                $display("FAIL rand_readdata cycle %0d: got %h expected %h", n, readdata, m_rd);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL rand_irq cycle %0d: got %b expected %b", n, irq, m_irq);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fall_edge();
        test_mask();
        test_glitch();
        test_back_to_back();
        test_reset_mid_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
